// File: rtl/lane_mem_arbiter.sv
// Round-robin arbiter that shares one memory A/D port between NUM_LANES lanes.
// Requests go through a registered stage; responses are routed combinationally by source tag.
module lane_mem_arbiter #(
  parameter int NUM_LANES     = 4,
  parameter int DATA_WIDTH    = 64,
  parameter int LOGSIZE_WIDTH = 8,
  parameter int MAX_INFLIGHT  = 8,
  parameter int SRC_WIDTH     = $clog2(NUM_LANES)
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NUM_LANES-1:0]               lane_a_valid,
  output logic [NUM_LANES-1:0]               lane_a_ready,
  input  logic [DATA_WIDTH*NUM_LANES-1:0]    lane_a_address,
  input  logic [NUM_LANES-1:0]               lane_a_is_store,
  input  logic [LOGSIZE_WIDTH*NUM_LANES-1:0] lane_a_size,
  input  logic [DATA_WIDTH*NUM_LANES-1:0]    lane_a_data,
  output logic [NUM_LANES-1:0]               lane_d_valid,
  input  logic [NUM_LANES-1:0]               lane_d_ready,
  output logic [NUM_LANES-1:0]               lane_d_is_store,
  output logic [LOGSIZE_WIDTH*NUM_LANES-1:0] lane_d_size,
  output logic [DATA_WIDTH*NUM_LANES-1:0]    lane_d_data,
  output logic                               mem_a_valid,
  input  logic                               mem_a_ready,
  output logic [SRC_WIDTH-1:0]               mem_a_source,
  output logic [DATA_WIDTH-1:0]              mem_a_address,
  output logic                               mem_a_is_store,
  output logic [LOGSIZE_WIDTH-1:0]           mem_a_size,
  output logic [DATA_WIDTH-1:0]              mem_a_data,
  input  logic                               mem_d_valid,
  output logic                               mem_d_ready,
  input  logic [SRC_WIDTH-1:0]               mem_d_source,
  input  logic                               mem_d_is_store,
  input  logic [LOGSIZE_WIDTH-1:0]           mem_d_size,
  input  logic [DATA_WIDTH-1:0]              mem_d_data,
  output logic                               inflight,
  output logic                               err
);

  localparam int CNT_WIDTH = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_INFLIGHT);

  logic                     mem_a_valid_reg;
  logic [SRC_WIDTH-1:0]     mem_a_source_reg;
  logic [DATA_WIDTH-1:0]    mem_a_address_reg;
  logic                     mem_a_is_store_reg;
  logic [LOGSIZE_WIDTH-1:0] mem_a_size_reg;
  logic [DATA_WIDTH-1:0]    mem_a_data_reg;
  logic [SRC_WIDTH-1:0]     ptr_reg;
  logic [SRC_WIDTH-1:0]     ptr_next;
  logic [CNT_WIDTH-1:0]     cnt_reg;
  logic                     err_reg;

  logic                     gnt_en;
  logic [NUM_LANES-1:0]     a_fire_vec;
  logic                     a_fire;
  logic [SRC_WIDTH-1:0]     gnt_idx;
  logic [DATA_WIDTH-1:0]    sel_address;
  logic                     sel_is_store;
  logic [LOGSIZE_WIDTH-1:0] sel_size;
  logic [DATA_WIDTH-1:0]    sel_data;
  logic                     src_ok;
  logic                     d_fire;
  logic                     d_dec;

  // Reset also masks readies so no lane believes a request was taken that reset discards.
  assign gnt_en = !reset && (!mem_a_valid_reg || mem_a_ready) && (cnt_reg < CNT_MAX);

  function automatic int rr_dist(input int lane, input int base);
    return (lane - base + NUM_LANES) % NUM_LANES;
  endfunction

  assign src_ok = int'(mem_d_source) < NUM_LANES;

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic blocked;

      // A lane is only blocked by valid lanes ahead of it in round-robin order, never by itself.
      always_comb begin
        blocked = 1'b0;
        for (int j = 0; j < NUM_LANES; j++) begin
          if (lane_a_valid[j] && (rr_dist(j, int'(ptr_reg)) < rr_dist(gi, int'(ptr_reg))))
            blocked = 1'b1;
        end
      end

      assign lane_a_ready[gi] = gnt_en && !blocked;
      assign a_fire_vec[gi]   = lane_a_ready[gi] && lane_a_valid[gi];

      assign lane_d_valid[gi]    = mem_d_valid && src_ok && (mem_d_source == SRC_WIDTH'(gi));
      assign lane_d_is_store[gi] = mem_d_is_store;
      assign lane_d_size[LOGSIZE_WIDTH*gi +: LOGSIZE_WIDTH] = mem_d_size;
      assign lane_d_data[DATA_WIDTH*gi +: DATA_WIDTH]       = mem_d_data;
    end
  endgenerate

  assign a_fire = |a_fire_vec;

  always_comb begin
    gnt_idx      = '0;
    sel_address  = '0;
    sel_is_store = 1'b0;
    sel_size     = '0;
    sel_data     = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (a_fire_vec[i]) begin
        gnt_idx      = SRC_WIDTH'(i);
        sel_address  = lane_a_address[DATA_WIDTH*i +: DATA_WIDTH];
        sel_is_store = lane_a_is_store[i];
        sel_size     = lane_a_size[LOGSIZE_WIDTH*i +: LOGSIZE_WIDTH];
        sel_data     = lane_a_data[DATA_WIDTH*i +: DATA_WIDTH];
      end
    end
  end

  assign ptr_next = (int'(gnt_idx) == NUM_LANES - 1) ? '0 : gnt_idx + SRC_WIDTH'(1);

  // Out-of-range sources are always accepted so a bad beat cannot wedge the memory.
  always_comb begin
    mem_d_ready = !src_ok;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (mem_d_source == SRC_WIDTH'(i))
        mem_d_ready = lane_d_ready[i];
    end
  end

  assign d_fire = mem_d_valid && mem_d_ready;
  assign d_dec  = d_fire && src_ok && (cnt_reg != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_a_valid_reg    <= 1'b0;
      mem_a_source_reg   <= '0;
      mem_a_address_reg  <= '0;
      mem_a_is_store_reg <= 1'b0;
      mem_a_size_reg     <= '0;
      mem_a_data_reg     <= '0;
      ptr_reg            <= '0;
      cnt_reg            <= '0;
      err_reg            <= 1'b0;
    end else begin
      if (a_fire) begin
        mem_a_valid_reg    <= 1'b1;
        mem_a_source_reg   <= gnt_idx;
        mem_a_address_reg  <= sel_address;
        mem_a_is_store_reg <= sel_is_store;
        mem_a_size_reg     <= sel_size;
        mem_a_data_reg     <= sel_data;
        ptr_reg            <= ptr_next;
      end else if (mem_a_ready) begin
        mem_a_valid_reg <= 1'b0;
      end

      if (a_fire && !d_dec)
        cnt_reg <= cnt_reg + CNT_WIDTH'(1);
      else if (!a_fire && d_dec)
        cnt_reg <= cnt_reg - CNT_WIDTH'(1);

      if (d_fire && (!src_ok || (cnt_reg == '0)))
        err_reg <= 1'b1;
    end
  end

  assign mem_a_valid    = mem_a_valid_reg;
  assign mem_a_source   = mem_a_source_reg;
  assign mem_a_address  = mem_a_address_reg;
  assign mem_a_is_store = mem_a_is_store_reg;
  assign mem_a_size     = mem_a_size_reg;
  assign mem_a_data     = mem_a_data_reg;
  assign inflight       = mem_a_valid_reg || (cnt_reg != '0);
  assign err            = err_reg;

endmodule

// File: tb/tb_lane_mem_arbiter.sv
// Bench for lane_mem_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_lane_mem_arbiter;
  localparam int N    = 4;
  localparam int DW   = 64;
  localparam int LW   = 8;
  localparam int MAXI = 8;
  localparam int SW   = 3;  // one spare bit so out-of-range sources can be driven

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [N-1:0]    lane_a_valid, lane_a_ready, lane_a_is_store;
  logic [N-1:0]    lane_d_valid, lane_d_ready, lane_d_is_store;
  logic [DW*N-1:0] lane_a_address, lane_a_data, lane_d_data;
  logic [LW*N-1:0] lane_a_size, lane_d_size;
  logic            mem_a_valid, mem_a_ready, mem_a_is_store;
  logic            mem_d_valid, mem_d_ready, mem_d_is_store;
  logic [SW-1:0]   mem_a_source, mem_d_source;
  logic [DW-1:0]   mem_a_address, mem_a_data, mem_d_data;
  logic [LW-1:0]   mem_a_size, mem_d_size;
  logic            inflight, err;

  lane_mem_arbiter #(
    .NUM_LANES(N), .DATA_WIDTH(DW), .LOGSIZE_WIDTH(LW), .MAX_INFLIGHT(MAXI), .SRC_WIDTH(SW)
  ) dut (
    .clock(clock), .reset(reset),
    .lane_a_valid(lane_a_valid), .lane_a_ready(lane_a_ready), .lane_a_address(lane_a_address),
    .lane_a_is_store(lane_a_is_store), .lane_a_size(lane_a_size), .lane_a_data(lane_a_data),
    .lane_d_valid(lane_d_valid), .lane_d_ready(lane_d_ready), .lane_d_is_store(lane_d_is_store),
    .lane_d_size(lane_d_size), .lane_d_data(lane_d_data),
    .mem_a_valid(mem_a_valid), .mem_a_ready(mem_a_ready), .mem_a_source(mem_a_source),
    .mem_a_address(mem_a_address), .mem_a_is_store(mem_a_is_store), .mem_a_size(mem_a_size),
    .mem_a_data(mem_a_data),
    .mem_d_valid(mem_d_valid), .mem_d_ready(mem_d_ready), .mem_d_source(mem_d_source),
    .mem_d_is_store(mem_d_is_store), .mem_d_size(mem_d_size), .mem_d_data(mem_d_data),
    .inflight(inflight), .err(err)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: held request, next-in-line lane, outstanding count, sticky error.
  logic        m_valid;
  int          m_src, m_ptr, m_cnt;
  logic [63:0] m_addr, m_data;
  logic        m_store;
  logic [7:0]  m_size;
  logic        m_err;
  int          n_grants;
  int          txn = 0;
  int          rr_seen[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic rand_fields();
    for (int i = 0; i < N; i++) begin
      lane_a_address[DW*i +: DW] = {$urandom, $urandom};
      lane_a_data[DW*i +: DW]    = {$urandom, $urandom};
      lane_a_size[LW*i +: LW]    = LW'($urandom_range(0, 6));
      lane_a_is_store[i]         = 1'($urandom_range(0, 1));
    end
    mem_d_data     = {$urandom, $urandom};
    mem_d_size     = LW'($urandom_range(0, 6));
    mem_d_is_store = 1'($urandom_range(0, 1));
  endtask

  // One clock: check combinational outputs, take the edge, advance the model, check registers.
  task automatic step();
    int          g, src;
    logic        gnt_en, a_fire, d_fire, a_rdy;
    logic [N-1:0] exp_rdy, exp_dv;
    logic        exp_dr;
    logic [63:0] s_addr, s_data;
    logic        s_store;
    logic [7:0]  s_size;
    #2;
    gnt_en = !reset && (!m_valid || mem_a_ready) && (m_cnt < MAXI);
    g = -1;
    for (int k = 0; k < N; k++)
      if (g < 0 && lane_a_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    exp_rdy = '0;
    if (gnt_en && g >= 0) exp_rdy[g] = 1'b1;
    src = int'(mem_d_source);
    exp_dv = '0;
    exp_dr = 1'b1;
    if (src < N) begin
      exp_dv[src] = mem_d_valid;
      exp_dr      = lane_d_ready[src];
    end
    check("a_grant", 64'(lane_a_ready & lane_a_valid), 64'(exp_rdy));
    check("d_valid", 64'(lane_d_valid), 64'(exp_dv));
    check("d_ready", 64'(mem_d_ready), 64'(exp_dr));
    check("d_data_bcast", lane_d_data[DW*(N-1) +: DW], mem_d_data);
    check("d_size_bcast", 64'(lane_d_size[LW-1:0]), 64'(mem_d_size));
    a_fire = gnt_en && (g >= 0);
    d_fire = mem_d_valid && exp_dr;
    a_rdy  = mem_a_ready;
    s_addr = '0; s_data = '0; s_store = 1'b0; s_size = '0;
    if (g >= 0) begin
      s_addr  = lane_a_address[DW*g +: DW];
      s_data  = lane_a_data[DW*g +: DW];
      s_store = lane_a_is_store[g];
      s_size  = lane_a_size[LW*g +: LW];
    end
    @(posedge clock);
    #1;
    if (reset) begin
      m_valid = 1'b0; m_src = 0; m_addr = '0; m_store = 1'b0; m_size = '0; m_data = '0;
      m_ptr = 0; m_cnt = 0; m_err = 1'b0;
    end else begin
      if (a_fire) begin
        m_valid = 1'b1; m_src = g; m_addr = s_addr; m_store = s_store; m_size = s_size;
        m_data = s_data; m_ptr = (g + 1) % N; n_grants++;
      end else if (a_rdy) begin
        m_valid = 1'b0;
      end
      if (d_fire && (src >= N || m_cnt == 0)) m_err = 1'b1;
      m_cnt = m_cnt + (a_fire ? 1 : 0) - ((d_fire && src < N && m_cnt > 0) ? 1 : 0);
    end
    check("a_valid", 64'(mem_a_valid), 64'(m_valid));
    check("a_source", 64'(mem_a_source), 64'(m_src));
    check("a_address", mem_a_address, m_addr);
    check("a_is_store", 64'(mem_a_is_store), 64'(m_store));
    check("a_size", 64'(mem_a_size), 64'(m_size));
    check("a_data", mem_a_data, m_data);
    check("inflight", 64'(inflight), 64'(m_valid || m_cnt != 0));
    check("err", 64'(err), 64'(m_err));
    txn++;
    $display("txn %0d rst=%0b grant=%0d d_fire=%0b d_src=%0d cnt=%0d", txn, reset, a_fire ? g : -1,
             d_fire, src, m_cnt);
  endtask

  task automatic drain();
    lane_a_valid = '0;
    mem_a_ready  = 1'b1;
    lane_d_ready = '1;
    mem_d_source = '0;
    for (int i = 0; i < 30 && (m_cnt > 0 || m_valid); i++) begin
      mem_d_valid = (m_cnt > 0);
      step();
    end
    mem_d_valid = 1'b0;
    check("drained_inflight", 64'(inflight), 64'(0));
  endtask

  initial begin
    int rr_exp[6];
    rr_exp = '{0, 1, 2, 3, 0, 1};
    m_valid = 1'b0; m_src = 0; m_ptr = 0; m_cnt = 0; m_addr = '0; m_data = '0;
    m_store = 1'b0; m_size = '0; m_err = 1'b0; n_grants = 0;
    lane_a_valid = '1; lane_d_ready = '0; mem_a_ready = 1'b0;
    mem_d_valid = 1'b0; mem_d_source = '0;
    rand_fields();

    // Reset held three cycles with every lane requesting
    reset = 1'b1;
    @(posedge clock); #1;
    repeat (3) step();
    check("rst_ready", 64'(lane_a_ready & lane_a_valid), 64'(0));
    reset = 1'b0;

    // Round-robin order with immediate responses
    mem_a_ready = 1'b1;
    lane_d_ready = '1;
    for (int i = 0; i < 6; i++) begin
      rand_fields();
      mem_d_valid  = mem_a_valid;
      mem_d_source = mem_a_source;
      step();
      rr_seen.push_back(int'(mem_a_source));
    end
    for (int i = 0; i < 6; i++) check("rr_order", 64'(rr_seen[i]), 64'(rr_exp[i]));
    drain();

    // Backpressure on a lane-2 store
    mem_a_ready = 1'b0;
    lane_a_valid = 4'b0100;
    lane_a_address[DW*2 +: DW] = 64'h1000;
    lane_a_data[DW*2 +: DW]    = 64'hDEAD;
    lane_a_is_store[2]         = 1'b1;
    step();
    lane_a_valid = '1;
    for (int i = 0; i < 5; i++) begin
      rand_fields();
      step();
    end
    check("bp_addr", mem_a_address, 64'h1000);
    check("bp_data", mem_a_data, 64'hDEAD);
    check("bp_source", 64'(mem_a_source), 64'(2));
    mem_a_ready = 1'b1;
    lane_a_valid = '0;
    step();
    check("bp_accepted", 64'(mem_a_valid), 64'(0));
    drain();

    // Inflight limit with no responses, then one response re-opens grants a cycle later
    n_grants = 0;
    lane_a_valid = '1;
    mem_a_ready  = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("limit_grants", 64'(n_grants), 64'(8));
    mem_d_valid = 1'b1; mem_d_source = 3'd1; lane_d_ready = '1;
    step();
    check("limit_same_cycle", 64'(n_grants), 64'(8));
    mem_d_valid = 1'b0;
    step();
    check("limit_ninth", 64'(n_grants), 64'(9));
    check("limit_inflight", 64'(inflight), 64'(1));
    drain();

    // Routing to lane 3 with backpressure from the lane
    lane_a_valid = 4'b0001;
    step();
    lane_a_valid = '0;
    mem_d_valid = 1'b1; mem_d_source = 3'd3; lane_d_ready = 4'b0111;
    #2;
    check("route_dvalid", 64'(lane_d_valid), 64'(4'b1000));
    check("route_dready", 64'(mem_d_ready), 64'(0));
    step();
    lane_d_ready = '1;
    step();
    mem_d_valid = 1'b0;
    step();
    check("route_done", 64'(inflight), 64'(0));

    // Random traffic, responses only while the model has something outstanding
    for (int i = 0; i < 400; i++) begin
      rand_fields();
      reset        = ($urandom_range(0, 99) == 0);
      lane_a_valid = N'($urandom);
      mem_a_ready  = ($urandom_range(0, 3) != 0);
      lane_d_ready = N'($urandom);
      mem_d_source = SW'($urandom_range(0, N - 1));
      mem_d_valid  = (m_cnt > 0) && ($urandom_range(0, 2) != 0);
      step();
    end
    reset = 1'b0;
    drain();

    // Out-of-range source and underflow both set the sticky error
    mem_d_valid = 1'b1; mem_d_source = 3'd5; lane_d_ready = '0;
    #2;
    check("oor_dready", 64'(mem_d_ready), 64'(1));
    check("oor_dvalid", 64'(lane_d_valid), 64'(0));
    step();
    check("oor_err", 64'(err), 64'(1));
    mem_d_valid = 1'b0;
    step();
    check("oor_err_sticky", 64'(err), 64'(1));
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("err_cleared", 64'(err), 64'(0));
    mem_d_valid = 1'b1; mem_d_source = 3'd1; lane_d_ready = '1;
    step();
    mem_d_valid = 1'b0;
    check("uf_err", 64'(err), 64'(1));
    check("uf_inflight", 64'(inflight), 64'(0));
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0t exp=finish", $time);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/lane_mem_arbiter.md
# lane_mem_arbiter

Round-robin arbiter that shares one memory request/response port between `NUM_LANES` per-lane traffic generators, such as the per-lane emulator lanes, and the single-port simulation memory. It registers the A (request) channel, tags each request with its lane index as `source`, and routes D (response) beats back to the originating lane by `source`. It bounds total outstanding requests and drives the aggregate `inflight` status that the emulator uses for end-of-test detection.

## Interface
Parameters:
- `NUM_LANES`, 4, number of requesting lanes (≥2).
- `DATA_WIDTH`, 64, address and data width per lane.
- `LOGSIZE_WIDTH`, 8, log2-size field width per lane.
- `MAX_INFLIGHT`, 8, maximum accepted-but-unanswered requests (≥1).
- `SRC_WIDTH`, $clog2(NUM_LANES), source tag width (derived).

Ports (clock and reset: reset is synchronous and active-high; the clock is `clock`):
- `clock`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `lane_a_valid`  in  NUM_LANES  per-lane request valid.
- `lane_a_ready`  out  NUM_LANES  per-lane request ready; one-hot or zero.
- `lane_a_address`  in  DATA_WIDTH*NUM_LANES  lane i at `[DATA_WIDTH*i +: DATA_WIDTH]`.
- `lane_a_is_store`  in  NUM_LANES  per-lane store flag.
- `lane_a_size`  in  LOGSIZE_WIDTH*NUM_LANES  per-lane log2 size.
- `lane_a_data`  in  DATA_WIDTH*NUM_LANES  per-lane store data.
- `lane_d_valid`  out  NUM_LANES  per-lane response valid.
- `lane_d_ready`  in  NUM_LANES  per-lane response ready.
- `lane_d_is_store`, `lane_d_size`, `lane_d_data`  out  same widths as the A fields  response fields, broadcast to all lanes; qualified per lane by `lane_d_valid`.
- `mem_a_valid`  out  1  registered request valid.
- `mem_a_ready`  in  1  memory accepts the request.
- `mem_a_source`  out  SRC_WIDTH  lane index of the request.
- `mem_a_address`, `mem_a_is_store`, `mem_a_size`, `mem_a_data`  out  single-lane widths  registered request fields.
- `mem_d_valid`  in  1  response valid.
- `mem_d_ready`  out  1  response ready.
- `mem_d_source`, `mem_d_is_store`, `mem_d_size`, `mem_d_data`  in  single-lane widths  response fields.
- `inflight`  out  1  high if any request is held or outstanding.
- `err`  out  1  sticky protocol-error flag.

## Operation
- **State:**
  - Output register `{valid, source, address, is_store, size, data}`.
  - Round-robin pointer `ptr` (SRC_WIDTH bits).
  - Outstanding counter `cnt`, $clog2(MAX_INFLIGHT+1) bits.
  - `err`.
- **Grant enable:** `gnt_en = (!mem_a_valid || mem_a_ready) && (cnt < MAX_INFLIGHT)`.
- **Grant selection:** the first lane with `lane_a_valid` set, searching `ptr, ptr+1, …` with wrap at NUM_LANES. That lane's `lane_a_ready` is high when `gnt_en`; all other lanes' `lane_a_ready` are 0. `lane_a_ready` must not depend on the lane's own `lane_a_valid`; it may depend on the other lanes' valids.
- **On lane A fire (lane g):**
  - The output register loads lane g's fields and `source = g`.
  - `ptr <= (g+1) mod NUM_LANES`.
  - `cnt` increments.
- **Output register drain:** on `mem_a_valid && mem_a_ready` with no new grant, `mem_a_valid <= 0`.
- **Fields stable under backpressure:** while `mem_a_valid && !mem_a_ready`, all `mem_a_*` outputs hold stable.
- **Response routing:**
  - `lane_d_valid[i] = mem_d_valid && mem_d_source == i`.
  - `mem_d_ready = lane_d_ready[mem_d_source]`. Routing is combinational.
- **On D fire with a valid source:** `cnt` decrements. A simultaneous lane A fire and D fire leaves `cnt` unchanged.
- **Out-of-range source (`mem_d_source ≥ NUM_LANES`):** `mem_d_ready = 1`, no `lane_d_valid` is asserted, `cnt` is unchanged, and `err <= 1`.
- **Underflow (D fire while `cnt == 0`):** `cnt` stays 0 and `err <= 1`.
- **Inflight status:** `inflight = mem_a_valid || (cnt != 0)`, combinational from registers.
- **Reset:**
  - `mem_a_valid = 0`, `ptr = 0`, `cnt = 0`, `err = 0`.
  - Registered fields clear to 0.
  - Consequently `inflight = 0` and `lane_a_ready` depends only on valids.
  - A mid-operation reset discards the held request and the outstanding count. Responses arriving after reset are treated as underflow.

## Timing
- **Request latency:** a lane A fire at edge N gives `mem_a_valid = 1` with that request's fields in cycle N+1.
- **Throughput:** one request per cycle when `mem_a_ready` is held high and `cnt` stays below MAX_INFLIGHT. The grant uses same-cycle drain, so there is no bubble.
- **Response latency:** D routing has zero-cycle latency.
- **Counter-full recovery:** when `cnt == MAX_INFLIGHT`, a D fire in cycle N re-enables grants in cycle N+1, not in cycle N.
- **Fairness:** with all lanes continuously valid, grants cycle 0, 1, …, NUM_LANES-1, 0, …; no lane waits more than NUM_LANES-1 grants.

## Test plan
- **Reset check:** assert reset 3 cycles with all lanes valid. All `lane_a_ready` = 0, `mem_a_valid` = 0, `inflight` = 0, `err` = 0.
- **Round-robin order:** all 4 lanes valid, `mem_a_ready` = 1, D responses returned immediately. `mem_a_source` sequence is 0,1,2,3,0,1 on consecutive cycles with `mem_a_address` matching each lane.
- **Backpressure:** lane 2 stores address 0x1000, data 0xDEAD; hold `mem_a_ready` = 0 for 5 cycles. `mem_a_*` stay stable, no other lane is granted, then the request is accepted on the first ready cycle.
- **Inflight limit:** MAX_INFLIGHT = 8 with no D responses. Exactly 8 grants occur, then `lane_a_ready` = 0. One D fire allows the 9th grant on the following cycle; `inflight` stays 1 until all 9 responses return.
- **Response routing:** `mem_d_source` = 3 with `lane_d_ready[3]` = 0. `lane_d_valid` = 4'b1000 and `mem_d_ready` = 0; raising `lane_d_ready[3]` completes the beat and decrements `cnt`.
- **Error cases:** `mem_d_source` = 5 with NUM_LANES = 4 gives `mem_d_ready` = 1, no lane valid, `err` = 1 sticky. A D fire with `cnt` = 0 also sets `err`; `cnt` stays 0.
